// File: rtl/back_icon_dispatch_sched.sv
// In-order dispatch scheduler: staging FIFO feeding one ready interconnect channel per cycle, round-robin.
// Optional ICON_DISPATCH_STATS_EN adds saturating dispatch/stall counters.
module back_icon_dispatch_sched #(
  parameter int  NUM_ICON_CHANNELS = 4,
  parameter int  LOG2_FIFO_DEPTH   = 2,
  parameter type type_icon_instr   = logic [31:0]
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush_i,
  input  type_icon_instr                fe_instr_i,
  input  logic                          fe_instr_valid_i,
  output logic                          fe_instr_ready_o,
  output type_icon_instr                icon_instr_dispatch_o [NUM_ICON_CHANNELS],
  output logic [NUM_ICON_CHANNELS-1:0]  icon_instr_dispatch_valid_o,
  input  logic [NUM_ICON_CHANNELS-1:0]  icon_instr_dispatch_ready_i,
  output logic [LOG2_FIFO_DEPTH:0]      occupancy_o
`ifdef ICON_DISPATCH_STATS_EN
  ,
  output logic [31:0]                   dispatch_count_o,
  output logic [31:0]                   stall_count_o
`endif
);

  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam int RR_W  = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;

  // Handshake: a transfer happens on a clock edge where valid and ready are both high;
  // valid never depends on ready on the front-end side, and flush cancels any transfer.
  type_icon_instr             mem [DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [LOG2_FIFO_DEPTH:0]   count;
  logic [RR_W-1:0]            rr_ptr, sel;
  logic                       any_ready, head_valid, enq, deq;
  int                         idx;

  // Search ready channels starting at rr_ptr, wrapping modulo the channel count.
  always_comb begin
    sel       = rr_ptr;
    any_ready = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_ICON_CHANNELS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_ICON_CHANNELS) idx = idx - NUM_ICON_CHANNELS;
      if (!any_ready && icon_instr_dispatch_ready_i[RR_W'(idx)]) begin
        any_ready = 1'b1;
        sel       = RR_W'(idx);
      end
    end
  end

  assign fe_instr_ready_o = (count != (LOG2_FIFO_DEPTH+1)'(DEPTH));
  assign head_valid       = (count != '0);
  assign enq              = fe_instr_valid_i & fe_instr_ready_o & ~flush_i;
  assign deq              = head_valid & any_ready & ~flush_i;
  assign occupancy_o      = count;

  always_comb begin
    icon_instr_dispatch_valid_o = '0;
    for (int c = 0; c < NUM_ICON_CHANNELS; c++) icon_instr_dispatch_o[c] = '0;
    if (deq) begin
      icon_instr_dispatch_valid_o[sel] = 1'b1;
      icon_instr_dispatch_o[sel]       = mem[rd_ptr];
    end
  end

  // Storage needs no reset; entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= fe_instr_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
        rr_ptr <= (sel == RR_W'(NUM_ICON_CHANNELS-1)) ? '0 : sel + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ICON_DISPATCH_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dispatch_count_o <= '0;
      stall_count_o    <= '0;
    end else begin
      if (deq && dispatch_count_o != 32'hFFFF_FFFF) dispatch_count_o <= dispatch_count_o + 1'b1;
      if (head_valid && !any_ready && !flush_i && stall_count_o != 32'hFFFF_FFFF)
        stall_count_o <= stall_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_back_icon_dispatch_sched.sv
// Directed + random bench for back_icon_dispatch_sched with a reference model and expected-data queue.
// Build with ICON_DISPATCH_STATS_EN defined to also cover the statistics counters.
module tb_back_icon_dispatch_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [31:0] fe_instr;
  logic        fe_valid;
  logic        fe_ready;
  logic [31:0] disp [4];
  logic [3:0]  disp_valid;
  logic [3:0]  disp_ready;
  logic [2:0]  occ;
`ifdef ICON_DISPATCH_STATS_EN
  logic [31:0] disp_cnt, stall_cnt;
  int          m_disp, m_stall;
`endif

  int          errors = 0;
  int          checks = 0;
  int          m_count;
  int          m_rr;
  logic [31:0] exp_q [$];

  back_icon_dispatch_sched dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .flush_i                     (flush),
    .fe_instr_i                  (fe_instr),
    .fe_instr_valid_i            (fe_valid),
    .fe_instr_ready_o            (fe_ready),
    .icon_instr_dispatch_o       (disp),
    .icon_instr_dispatch_valid_o (disp_valid),
    .icon_instr_dispatch_ready_i (disp_ready),
    .occupancy_o                 (occ)
`ifdef ICON_DISPATCH_STATS_EN
    ,
    .dispatch_count_o            (disp_cnt),
    .stall_count_o               (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs against the model with current inputs, update model, advance.
  task automatic cycle();
    int          sel;
    logic        dispatch, accept, stall;
    logic [31:0] head;
    #1;
    if (reset_n) begin
      chk("occupancy", 64'(occ), 64'(m_count));
      chk("fe_ready", 64'(fe_ready), 64'(m_count != 4));
      chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
      sel = -1;
      for (int k = 0; k < 4; k++) begin
        int c = (m_rr + k) % 4;
        if (sel < 0 && disp_ready[c[1:0]]) sel = c;
      end
      dispatch = (m_count != 0) && (sel >= 0) && !flush;
      accept   = fe_valid && (m_count != 4) && !flush;
      stall    = (m_count != 0) && (sel < 0) && !flush;
      head     = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
      for (int c = 0; c < 4; c++) begin
        logic hit = dispatch && (c == sel);
        chk($sformatf("valid_ch%0d", c), 64'(disp_valid[c[1:0]]), 64'(hit));
        chk($sformatf("data_ch%0d", c), 64'(disp[c[1:0]]), hit ? 64'(head) : 64'h0);
      end
`ifdef ICON_DISPATCH_STATS_EN
      chk("dispatch_count", 64'(disp_cnt), 64'(m_disp));
      chk("stall_count", 64'(stall_cnt), 64'(m_stall));
      if (dispatch) m_disp++;
      if (stall) m_stall++;
`else
      if (stall) m_count = m_count + 0;
`endif
      if (flush) begin
        m_count = 0;
        m_rr    = 0;
        exp_q.delete();
      end else begin
        if (dispatch) begin
          void'(exp_q.pop_front());
          m_rr    = (sel + 1) % 4;
          m_count = m_count - 1;
        end
        if (accept) begin
          exp_q.push_back(fe_instr);
          m_count = m_count + 1;
        end
      end
    end else begin
      m_count = 0;
      m_rr    = 0;
      exp_q.delete();
`ifdef ICON_DISPATCH_STATS_EN
      m_disp  = 0;
      m_stall = 0;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    fe_valid = 1'b0;
    flush    = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] d);
    fe_valid = 1'b1;
    fe_instr = d;
    cycle();
    fe_valid = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    flush      = 1'b0;
    fe_valid   = 1'b0;
    fe_instr   = '0;
    disp_ready = 4'h0;
    m_count    = 0;
    m_rr       = 0;
`ifdef ICON_DISPATCH_STATS_EN
    m_disp  = 0;
    m_stall = 0;
`endif
    @(negedge clk);
    do_reset();
    chk("reset_occ", 64'(occ), 64'd0);
    chk("reset_ready", 64'(fe_ready), 64'd1);
    chk("reset_valid", 64'(disp_valid), 64'd0);

    // A,B,C,D with all channels ready: channels 0..3 in turn
    disp_ready = 4'hF;
    push(32'hA); push(32'hB); push(32'hC); push(32'hD);
    cycle();
    cycle();
    chk("rr_after_abcd", 64'(dut.rr_ptr), 64'd0);

    // only channel 2 ready
    disp_ready = 4'b0100;
    push(32'h21); push(32'h22); push(32'h23);
    cycle();
    cycle();
    chk("rr_ch2_only", 64'(dut.rr_ptr), 64'd3);

    // fill with nothing ready, then open channel 1
    disp_ready = 4'h0;
    push(32'h31); push(32'h32); push(32'h33); push(32'h34);
    chk("full_ready", 64'(fe_ready), 64'd0);
    chk("full_occ", 64'(occ), 64'd4);
    disp_ready = 4'b0010;
    cycle();
    chk("ready_after_first", 64'(fe_ready), 64'd1);
    repeat (4) cycle();

    // full FIFO with held input, single dispatch frees a slot
    disp_ready = 4'h0;
    push(32'h41); push(32'h42); push(32'h43); push(32'h44);
    fe_valid = 1'b1;
    fe_instr = 32'h45;
    cycle();
    cycle();
    disp_ready = 4'b0010;
    cycle();
    chk("occ_after_one", 64'(occ), 64'd3);
    disp_ready = 4'h0;
    cycle();
    chk("occ_refill", 64'(occ), 64'd4);
    fe_valid   = 1'b0;
    disp_ready = 4'hF;
    repeat (5) cycle();

    // flush with 3 queued and a valid input
    disp_ready = 4'h0;
    push(32'h51); push(32'h52); push(32'h53);
    disp_ready = 4'hF;
    flush      = 1'b1;
    fe_valid   = 1'b1;
    fe_instr   = 32'hDEAD;
    cycle();
    flush    = 1'b0;
    fe_valid = 1'b0;
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_rr", 64'(dut.rr_ptr), 64'd0);
    repeat (3) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      fe_valid   = 1'($urandom_range(0, 1));
      fe_instr   = $urandom;
      disp_ready = 4'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;

    // reset mid-operation discards buffered entries
    disp_ready = 4'h0;
    push(32'h61); push(32'h62);
    do_reset();
    chk("midreset_occ", 64'(occ), 64'd0);
    disp_ready = 4'hF;
    repeat (3) cycle();

`ifdef ICON_DISPATCH_STATS_EN
    do_reset();
    disp_ready = 4'h0;
    fe_valid   = 1'b1;
    fe_instr   = 32'h71;
    cycle();
    fe_instr = 32'h72;
    cycle();
    fe_valid = 1'b0;
    repeat (4) cycle();
    disp_ready = 4'hF;
    cycle();
    cycle();
    chk("stats_stall", 64'(stall_cnt), 64'd5);
    chk("stats_dispatch", 64'(disp_cnt), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
